writeback_arbiter: RTL and testbench

- Next-generation writeback stage: merges the in-order pipeline result with NUM_LATE long-latency result channels (divider, FPU, etc.) onto the single register-file write port.
- Pipeline results always win the port; late results are buffered in per-channel FIFOs and drained round-robin into idle port cycles.
- A starvation counter requests a one-cycle pipeline stall when late results have waited too long.
- Sits between the memory stage and the register file; the register-file write is registered (1-cycle latency).

---
 rtl/writeback_arbiter_if.sv | 38 +++
 rtl/writeback_arbiter.sv | 142 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - writeback arbiter pipeline, late-channel and register-file signal bundle
interface writeback_arbiter_if #(
    parameter int XLEN     = 32,
    parameter int NUM_LATE = 2
);
    logic                     stall_i;
    logic                     flush_i;
    logic                     pipe_wr_en_i;
    logic [4:0]               pipe_rd_addr_i;
    logic [1:0]               pipe_data_sel_i;
    logic [XLEN-1:0]          pipe_alu_result_i;
    logic [XLEN-1:0]          pipe_read_data_i;
    logic [XLEN-1:0]          pipe_pc_incr_i;
    logic [XLEN-1:0]          pipe_csr_data_i;
    logic [NUM_LATE-1:0]      late_valid_i;
    logic [NUM_LATE-1:0]      late_ready_o;
    logic [NUM_LATE*5-1:0]    late_rd_addr_i;
    logic [NUM_LATE*XLEN-1:0] late_data_i;
    logic                     rf_we_o;
    logic [4:0]               rf_waddr_o;
    logic [XLEN-1:0]          rf_wdata_o;
    logic [NUM_LATE-1:0]      late_retire_o;
    logic                     wb_stall_req_o;

    modport master (
        output stall_i, flush_i, pipe_wr_en_i, pipe_rd_addr_i, pipe_data_sel_i,
               pipe_alu_result_i, pipe_read_data_i, pipe_pc_incr_i, pipe_csr_data_i,
               late_valid_i, late_rd_addr_i, late_data_i,
        input  late_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, late_retire_o, wb_stall_req_o
    );

    modport slave (
        input  stall_i, flush_i, pipe_wr_en_i, pipe_rd_addr_i, pipe_data_sel_i,
               pipe_alu_result_i, pipe_read_data_i, pipe_pc_incr_i, pipe_csr_data_i,
               late_valid_i, late_rd_addr_i, late_data_i,
        output late_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, late_retire_o, wb_stall_req_o
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipeline and buffered late results onto one register-file write port
module writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int NUM_LATE   = 2,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    writeback_arbiter_if.slave  wb
);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int RRW = (NUM_LATE > 1) ? $clog2(NUM_LATE) : 1;
    localparam int SW  = $clog2(STARVE_LIM + 1);

    logic [4:0]          fifo_rd   [NUM_LATE][DEPTH];
    logic [XLEN-1:0]     fifo_data [NUM_LATE][DEPTH];
    logic [PW-1:0]       head      [NUM_LATE];
    logic [PW-1:0]       tail      [NUM_LATE];
    logic [CW-1:0]       count     [NUM_LATE];
    logic [NUM_LATE-1:0] nonempty, late_ready, enq, deq;
    logic [RRW-1:0]      rr, grant;
    logic                grant_valid, pipe_fire, any_pending;
    logic [SW-1:0]       starve_cnt;
    logic [XLEN-1:0]     pipe_data;
    logic                win_valid;
    logic [4:0]          win_rd;
    logic [XLEN-1:0]     win_data;
    logic                rf_we_q;
    logic [4:0]          rf_waddr_q;
    logic [XLEN-1:0]     rf_wdata_q;
    logic [NUM_LATE-1:0] retire_q;

    function automatic logic [RRW-1:0] wrap_idx(input int base, input int off);
        return RRW'((base + off) % NUM_LATE);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on occupancy: a same-cycle dequeue never frees a slot for an enqueue.
    always_comb begin
        nonempty   = '0;
        late_ready = '0;
        enq        = '0;
        for (int i = 0; i < NUM_LATE; i++) begin
            nonempty[i]   = (count[i] != '0);
            late_ready[i] = (count[i] != CW'(DEPTH));
            enq[i]        = wb.late_valid_i[i] & late_ready[i];
        end
    end

    assign pipe_fire   = wb.pipe_wr_en_i & ~wb.flush_i & ~wb.stall_i;
    assign any_pending = |nonempty;

    always_comb begin
        case (wb.pipe_data_sel_i)
            2'b00:   pipe_data = wb.pipe_alu_result_i;
            2'b01:   pipe_data = wb.pipe_read_data_i;
            2'b10:   pipe_data = wb.pipe_pc_incr_i;
            default: pipe_data = wb.pipe_csr_data_i;
        endcase
    end

    // Round-robin search starting at rr; the pipeline pre-empts any late grant.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = 0; k < NUM_LATE; k++) begin
            if (!grant_valid && !pipe_fire && nonempty[wrap_idx(int'(rr), k)]) begin
                grant_valid = 1'b1;
                grant       = wrap_idx(int'(rr), k);
            end
        end
    end

    always_comb begin
        deq       = grant_valid ? (NUM_LATE'(1) << grant) : '0;
        win_valid = pipe_fire | grant_valid;
        win_rd    = pipe_fire ? wb.pipe_rd_addr_i : fifo_rd[grant][head[grant]];
        win_data  = pipe_fire ? pipe_data : fifo_data[grant][head[grant]];
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_LATE; i++) begin
            if (enq[i]) begin
                fifo_rd[i][tail[i]]   <= wb.late_rd_addr_i[5*i +: 5];
                fifo_data[i][tail[i]] <= wb.late_data_i[XLEN*i +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LATE; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr         <= '0;
            starve_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_LATE; i++) begin
                if (enq[i]) tail[i] <= ptr_inc(tail[i]);
                if (deq[i]) head[i] <= ptr_inc(head[i]);
                count[i] <= count[i] + CW'(enq[i]) - CW'(deq[i]);
            end
            if (grant_valid) begin
                rr         <= wrap_idx(int'(grant), 1);
                starve_cnt <= '0;
            end else if (pipe_fire && any_pending && starve_cnt != SW'(STARVE_LIM)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    // Address and data hold on idle cycles; only the enable and retire strobes drop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            retire_q   <= '0;
        end else begin
            rf_we_q  <= win_valid & (win_rd != 5'd0);
            retire_q <= deq;
            if (win_valid) begin
                rf_waddr_q <= win_rd;
                rf_wdata_q <= win_data;
            end
        end
    end

    assign wb.late_ready_o   = late_ready;
    assign wb.rf_we_o        = rf_we_q;
    assign wb.rf_waddr_o     = rf_waddr_q;
    assign wb.rf_wdata_o     = rf_wdata_q;
    assign wb.late_retire_o  = retire_q;
    assign wb.wb_stall_req_o = (starve_cnt == SW'(STARVE_LIM));
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized and directed bench for writeback_arbiter against a queue model
module tb_writeback_arbiter;
    localparam int XLEN  = 32;
    localparam int NL    = 2;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    writeback_arbiter_if #(.XLEN(XLEN), .NUM_LATE(NL)) wb ();

    writeback_arbiter #(.XLEN(XLEN), .NUM_LATE(NL), .DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wb.slave)
    );

    always #5 clk = ~clk;

    logic [36:0] mq [NL][$];
    int          rr_m, starve_m;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [NL-1:0] exp_ret;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [NL-1:0] rdy;
        logic          fire, any, win;
        logic [4:0]    wrd;
        logic [31:0]   wdat;
        logic [36:0]   e;
        if (rst) begin
            for (int c = 0; c < NL; c++) mq[c].delete();
            rr_m = 0; starve_m = 0;
            exp_we = 0; exp_addr = 0; exp_data = 0; exp_ret = 0;
            return;
        end
        any = 0;
        for (int c = 0; c < NL; c++) begin
            rdy[c] = (mq[c].size() < DEPTH);
            if (mq[c].size() != 0) any = 1;
        end
        fire = wb.pipe_wr_en_i && !wb.flush_i && !wb.stall_i;
        win = 0; wrd = 0; wdat = 0; exp_ret = 0;
        if (fire) begin
            win = 1;
            wrd = wb.pipe_rd_addr_i;
            case (wb.pipe_data_sel_i)
                2'd0: wdat = wb.pipe_alu_result_i;
                2'd1: wdat = wb.pipe_read_data_i;
                2'd2: wdat = wb.pipe_pc_incr_i;
                default: wdat = wb.pipe_csr_data_i;
            endcase
        end else begin
            for (int k = 0; k < NL; k++) begin
                int c;
                c = (rr_m + k) % NL;
                if (!win && mq[c].size() > 0) begin
                    e = mq[c].pop_front();
                    win = 1; wrd = e[36:32]; wdat = e[31:0];
                    exp_ret[c] = 1'b1;
                    rr_m = (c + 1) % NL;
                end
            end
        end
        if (exp_ret != 0) starve_m = 0;
        else if (fire && any && starve_m < LIM) starve_m++;
        for (int c = 0; c < NL; c++)
            if (wb.late_valid_i[c] && rdy[c])
                mq[c].push_back({wb.late_rd_addr_i[5*c +: 5], wb.late_data_i[32*c +: 32]});
        exp_we = win && (wrd != 0);
        if (win) begin exp_addr = wrd; exp_data = wdat; end
    endtask

    task automatic cycle();
        logic [NL-1:0] exp_rdy;
        model_step();
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < NL; c++) exp_rdy[c] = (mq[c].size() < DEPTH);
        check_eq("rf_we", 64'(wb.rf_we_o), 64'(exp_we));
        check_eq("rf_waddr", 64'(wb.rf_waddr_o), 64'(exp_addr));
        check_eq("rf_wdata", 64'(wb.rf_wdata_o), 64'(exp_data));
        check_eq("late_retire", 64'(wb.late_retire_o), 64'(exp_ret));
        check_eq("late_ready", 64'(wb.late_ready_o), 64'(exp_rdy));
        check_eq("stall_req", 64'(wb.wb_stall_req_o), 64'(starve_m == LIM));
    endtask

    task automatic idle();
        wb.stall_i = 0; wb.flush_i = 0; wb.pipe_wr_en_i = 0;
        wb.pipe_rd_addr_i = 0; wb.pipe_data_sel_i = 0;
        wb.late_valid_i = 0; wb.late_rd_addr_i = 0; wb.late_data_i = 0;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [1:0] sel);
        wb.pipe_wr_en_i = 1; wb.pipe_rd_addr_i = rd; wb.pipe_data_sel_i = sel;
    endtask

    task automatic push(input int c, input logic [4:0] rd, input logic [31:0] d);
        wb.late_valid_i[c] = 1'b1;
        wb.late_rd_addr_i[5*c +: 5] = rd;
        wb.late_data_i[32*c +: 32] = d;
    endtask

    initial begin
        idle();
        wb.pipe_alu_result_i = 32'h1234;
        wb.pipe_read_data_i  = 32'h5555_0001;
        wb.pipe_pc_incr_i    = 32'h0000_0104;
        wb.pipe_csr_data_i   = 32'hC5C5_0300;
        rst = 1;
        cycle(); cycle();
        rst = 0;

        for (int s = 0; s < 4; s++) begin
            pipe(5'd5, 2'(s)); cycle();
            check_eq("pipe_sel_data", 64'(wb.rf_wdata_o),
                     64'((s == 0) ? 32'h1234 : (s == 1) ? 32'h5555_0001 :
                         (s == 2) ? 32'h0000_0104 : 32'hC5C5_0300));
        end
        idle(); pipe(5'd9, 2'd0); wb.flush_i = 1; cycle();
        check_eq("flush_no_we", 64'(wb.rf_we_o), 64'd0);
        idle(); pipe(5'd9, 2'd0); wb.stall_i = 1; cycle();
        idle(); pipe(5'd0, 2'd0); cycle();
        check_eq("rd0_no_we", 64'(wb.rf_we_o), 64'd0);

        idle(); push(0, 5'd7, 32'hAAAA); cycle();
        idle(); cycle(); cycle();
        check_eq("late_waddr", 64'(wb.rf_waddr_o), 64'd7);
        idle(); push(0, 5'd0, 32'hBBBB); cycle();
        idle(); cycle(); cycle();

        idle(); pipe(5'd3, 2'd0);
        push(0, 5'd10, 32'hA0); push(1, 5'd11, 32'hB0); cycle();
        push(0, 5'd12, 32'hA1); push(1, 5'd13, 32'hB1); cycle();
        check_eq("full_not_ready", 64'(wb.late_ready_o), 64'd0);
        idle(); repeat (5) cycle();

        idle(); pipe(5'd4, 2'd0); push(1, 5'd20, 32'hDEAD); cycle();
        wb.late_valid_i = 0; repeat (4) cycle();
        check_eq("starve_after_lim", 64'(wb.wb_stall_req_o), 64'd1);
        wb.stall_i = 1; cycle();
        idle(); cycle();

        idle(); pipe(5'd6, 2'd0); push(0, 5'd1, 32'h11); push(1, 5'd2, 32'h22); cycle();
        rst = 1; idle(); cycle();
        rst = 0; cycle(); cycle();
        check_eq("reset_ready", 64'(wb.late_ready_o), 64'h3);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            wb.pipe_wr_en_i      = ($urandom_range(0, 99) < 55);
            wb.flush_i           = ($urandom_range(0, 99) < 10);
            wb.stall_i           = wb.wb_stall_req_o ? 1'b1 : ($urandom_range(0, 99) < 10);
            wb.pipe_rd_addr_i    = 5'($urandom_range(0, 31));
            wb.pipe_data_sel_i   = 2'($urandom_range(0, 3));
            wb.pipe_alu_result_i = $urandom;
            wb.pipe_read_data_i  = $urandom;
            wb.pipe_pc_incr_i    = $urandom;
            wb.pipe_csr_data_i   = $urandom;
            for (int c = 0; c < NL; c++) begin
                wb.late_valid_i[c]          = ($urandom_range(0, 99) < 40);
                wb.late_rd_addr_i[5*c +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wb.late_data_i[32*c +: 32]  = $urandom;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
